// File: rtl/hashtable_pkg.sv
// hashtable_pkg: shared widths and types for the hash-table lookup path
package hashtable_pkg;
  localparam int KEY_W     = 64;
  localparam int LUP_REQ_W = 96;
  localparam int LUP_RSP_W = 120;
  typedef logic [KEY_W-1:0]     lup_key_t;
  typedef logic [LUP_REQ_W-1:0] lup_req_t;
  typedef logic [LUP_RSP_W-1:0] lup_rsp_t;
endpackage

// File: rtl/lup_order_fifo.sv
// lup_order_fifo: synchronous FIFO holding requester indices in grant order
module lup_order_fifo #(
  parameter int W = 1,
  parameter int DEPTH = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/hashtable_lup_arbiter.sv
// hashtable_lup_arbiter: round-robin sharing of the hash-table lookup port with in-order response routing; optional counters via HASHTABLE_LUP_STATS_EN
module hashtable_lup_arbiter
  import hashtable_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     s_req_valid,
  input  logic [NUM_REQ*64-1:0]  s_req_data,
  output logic [NUM_REQ-1:0]     s_req_ready,
  output logic                   m_lup_req_valid,
  output logic [95:0]            m_lup_req_data,
  input  logic                   m_lup_req_ready,
  input  logic                   s_lup_rsp_valid,
  input  logic [119:0]           s_lup_rsp_data,
  output logic                   s_lup_rsp_ready,
  output logic [NUM_REQ-1:0]     m_rsp_valid,
  output logic [119:0]           m_rsp_data,
  input  logic [NUM_REQ-1:0]     m_rsp_ready,
  output logic                   err_orphan_rsp,
  output logic [NUM_REQ*32-1:0]  stat_grant_cnt,
  output logic [31:0]            stat_stall_cnt
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1) + 1;
  logic [IW-1:0]      ptr, gidx, head;
  logic [NUM_REQ-1:0] gnt;
  logic               gany, can_issue, empty, full, pop;
  logic [CW-1:0]      cnt;
  lup_key_t           key;
  lup_req_t           req_q;
  int                 j;
  // Gated by rst_n so that no grant is offered while reset is held
  assign can_issue = rst_n && (!m_lup_req_valid || m_lup_req_ready) && (cnt < CW'(MAX_OUTSTANDING));
  always_comb begin
    gnt  = '0;
    gidx = '0;
    j    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (can_issue && !(|gnt) && s_req_valid[j]) begin
        gnt[j] = 1'b1;
        gidx   = IW'(j);
      end
    end
  end
  assign gany           = |gnt;
  assign s_req_ready    = gnt;
  assign key            = s_req_data[KEY_W*int'(gidx) +: KEY_W];
  assign m_lup_req_data = req_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lup_req_valid <= 1'b0;
      req_q           <= '0;
      ptr             <= '0;
      err_orphan_rsp  <= 1'b0;
    end else begin
      if (gany) begin
        m_lup_req_valid <= 1'b1;
        req_q           <= {{(LUP_REQ_W-KEY_W){1'b0}}, key};
        ptr             <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end else if (m_lup_req_ready) begin
        m_lup_req_valid <= 1'b0;
      end
      if (s_lup_rsp_valid && empty) err_orphan_rsp <= 1'b1;
    end
  end
  lup_order_fifo #(.W(IW), .DEPTH(MAX_OUTSTANDING)) u_order (
    .clk(clk), .rst_n(rst_n), .push(gany && !full), .din(gidx),
    .pop(pop), .dout(head), .empty(empty), .full(full), .count(cnt)
  );
  // Hash table answers in order, so the FIFO head names the response owner
  assign m_rsp_valid     = (s_lup_rsp_valid && !empty) ? (NUM_REQ'(1) << head) : '0;
  assign m_rsp_data      = s_lup_rsp_data;
  assign s_lup_rsp_ready = !empty && m_rsp_ready[head];
  assign pop             = s_lup_rsp_valid && s_lup_rsp_ready;
`ifdef HASHTABLE_LUP_STATS_EN
  logic [NUM_REQ-1:0][31:0] gcnt;
  logic [31:0]              scnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
      scnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gcnt[i] <= gcnt[i] + 32'd1;
      if (|s_req_valid && !gany) scnt <= scnt + 32'd1;
    end
  end
  assign stat_grant_cnt = gcnt;
  assign stat_stall_cnt = scnt;
`else
  assign stat_grant_cnt = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: doc/hashtable_lup_arbiter.md
Name: hashtable_lup_arbiter

Overview:
Shares the single hash-table lookup port between NUM_REQ requesters, for example the peer-request path and the host-side lookup path. Arbitration is round-robin. The block zero-extends each 64-bit key to the 96-bit lookup request and records the grant order. Because the hash table answers in order, each 120-bit lookup response is routed back to the requester that issued it. The block sits between the requester streams and the lookup request/response ports of the hash-table subsystem.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_OUTSTANDING, 8, lookups in flight (granted, response not yet delivered); power of two

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_req_valid  in  NUM_REQ  per-requester key valid
s_req_data  in  NUM_REQ*64  per-requester key; requester i occupies [64*i+63:64*i]
s_req_ready  out  NUM_REQ  per-requester key accepted
m_lup_req_valid  out  1  lookup request to hash table
m_lup_req_data  out  96  {32'h0, key}
m_lup_req_ready  in  1  hash table accepts request
s_lup_rsp_valid  in  1  lookup response from hash table
s_lup_rsp_data  in  120  lookup response
s_lup_rsp_ready  out  1  response accepted
m_rsp_valid  out  NUM_REQ  response valid to requester i
m_rsp_data  out  120  response data, shared by all requesters
m_rsp_ready  in  NUM_REQ  requester i accepts response
err_orphan_rsp  out  1  sticky: a response arrived with nothing outstanding
stat_grant_cnt  out  NUM_REQ*32  per-requester grant counters (optional feature)
stat_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; output register empty; order FIFO empty; outstanding count 0; round-robin pointer = 0.
- Output stage: a single request register.
  - can_issue = (!m_lup_req_valid || m_lup_req_ready) && (outstanding < MAX_OUTSTANDING).
  - Outstanding count is registered; a same-cycle pop does not free a slot until the next cycle.
- Arbitration:
  - When can_issue, grant the first valid requester searching from the pointer upward, mod NUM_REQ.
  - s_req_ready is one-hot (the grant only), or all 0.
  - On grant to i: the register loads {32'h0, key_i}; requester index i is pushed to the order FIFO; outstanding += 1; pointer = (i+1) mod NUM_REQ.
  - Latency: key accepted in cycle t → m_lup_req_valid in cycle t+1.
  - Full throughput: one grant per cycle while m_lup_req_ready=1 and slots remain.
- Request hold: m_lup_req_valid/data stay stable until m_lup_req_ready=1 (AXI-Stream rule).
- Response routing (combinational, zero latency):
  - h = order FIFO head.
  - m_rsp_valid[h] = s_lup_rsp_valid && !fifo_empty; all other m_rsp_valid bits are 0.
  - m_rsp_data = s_lup_rsp_data.
  - s_lup_rsp_ready = !fifo_empty && m_rsp_ready[h].
  - On handshake: pop the FIFO; outstanding -= 1.
- Simultaneous grant and response pop: count is unchanged; FIFO push and pop both occur.
- Orphan response (s_lup_rsp_valid=1 while FIFO empty):
  - s_lup_rsp_ready stays 0.
  - err_orphan_rsp is set and stays set until reset.
- Back-pressure from a slow requester stalls all responses (head-of-line blocking); this is intended.
- Counters wrap at 2^32.
- Reset mid-operation: in-flight requests are lost; the system reset also resets the hash table.

Optional Feature:
- Macro: HASHTABLE_LUP_STATS_EN.
- Defined:
  - stat_grant_cnt[i] increments on each grant to i.
  - stat_stall_cnt increments each cycle where |s_req_valid is true and no grant occurs.
  - Both counters reset to 0.
- Undefined:
  - ports are still present and tied to 0; no counter logic is instantiated.

Decomposition:
- Package hashtable_pkg:
  - KEY_W=64, LUP_REQ_W=96, LUP_RSP_W=120.
  - typedefs lup_key_t, lup_req_t, lup_rsp_t.
- Sub-module lup_order_fifo:
  - parameterised-width synchronous FIFO for requester indices, width $clog2(NUM_REQ) or at least 1, depth MAX_OUTSTANDING.
  - push/pop/empty/full, plus a count output.
- Arbiter and response routing stay in the top module.

Test Plan:
- Single request: requester 1 sends key 64'h1122334455667788 → m_lup_req_data=96'h0000_0000_1122334455667788 one cycle later; a response of 120'hABC… returned → m_rsp_valid=2'b10 with the same data.
- Both requesters continuously valid, ready=1 → grants alternate 0,1,0,1…; stat_grant_cnt equal after 100 cycles (±1).
- Hold m_lup_req_ready=0 for 5 cycles after a grant → m_lup_req_data stable; s_req_ready=0 throughout.
- 8 grants with no responses → s_req_ready=0 and stat_stall_cnt counts; one response delivered → next cycle a grant resumes.
- Responses in-order for grant sequence 0,0,1,0 → m_rsp_valid routes 01,01,10,01; hold m_rsp_ready[1]=0 → s_lup_rsp_ready=0 until released.
- s_lup_rsp_valid=1 after reset with no grants → err_orphan_rsp=1 sticky, s_lup_rsp_ready=0; assert rst_n=0 mid-burst → all outputs 0 immediately.
